// File: rtl/mem_read_arbiter_if.sv
// Read-port sharing bus between video fetch, secondary reader and instruction memory.
// The slave side belongs to the arbiter. The master side drives requests and memory data.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_timeout;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_addr, mem_rdata,
    output vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_timeout, mem_addr
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_addr, mem_rdata,
    input  vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_timeout, mem_addr
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Fixed-priority arbiter for the instruction_memory read port. Video requests always win.
// Each response comes back two cycles after its request and is tagged to the requester that issued it.
module mem_read_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_read_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_e;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  owner_e            owner_q, owner_d, owner_s2;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              gnt_d;
  logic [CNT_W-1:0]  cpu_wait_cnt, cnt_d;
  logic              timeout_q;
  logic              vid_rvalid_q, cpu_rvalid_q;
  logic [DATA_W-1:0] vid_rdata_q, cpu_rdata_q;

  // Slot decision. The memory address holds its last value when no requester is active.
  always_comb begin
    owner_d    = OWN_NONE;
    mem_addr_d = mem_addr_q;
    gnt_d      = 1'b0;
    if (bus.vid_req) begin
      owner_d    = OWN_VID;
      mem_addr_d = bus.vid_addr;
    end else if (bus.cpu_req) begin
      owner_d    = OWN_CPU;
      mem_addr_d = bus.cpu_addr;
      gnt_d      = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cpu_wait_cnt;
    if (!bus.cpu_req || gnt_d)
      cnt_d = '0;
    else if (cpu_wait_cnt != {CNT_W{1'b1}})
      cnt_d = cpu_wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_NONE;
      owner_s2     <= OWN_NONE;
      mem_addr_q   <= '0;
      cpu_wait_cnt <= '0;
      timeout_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      owner_s2     <= owner_q;
      mem_addr_q   <= mem_addr_d;
      cpu_wait_cnt <= cnt_d;
      // The timeout flag is taken from the next count, so it clears on the edge that grants.
      timeout_q    <= (cnt_d >= TIMEOUT_V);
      vid_rvalid_q <= (owner_s2 == OWN_VID);
      cpu_rvalid_q <= (owner_s2 == OWN_CPU);
      if (owner_s2 == OWN_VID) vid_rdata_q <= bus.mem_rdata;
      if (owner_s2 == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
    end
  end

  // The grant is masked while reset is held, so every output reads 0 during reset.
  assign bus.cpu_gnt     = gnt_d & rst;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.cpu_timeout = timeout_q;
  assign bus.vid_rvalid  = vid_rvalid_q;
  assign bus.vid_rdata   = vid_rdata_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter. It uses a one-cycle synchronous memory whose data is addr ^ 0xDEAD0000.
module tb_mem_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_rdata <= bus.mem_addr ^ 32'hDEAD_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] vexp [4];
    vexp[0] = 32'hDEAD_039C; vexp[1] = 32'hDEAD_03A0;
    vexp[2] = 32'hDEAD_03A4; vexp[3] = 32'hDEAD_03A8;
    bus.vid_req = 0; bus.vid_addr = 0; bus.cpu_req = 0; bus.cpu_addr = 0;
    bus.mem_rdata = 0;

    // reset state
    tick(); tick();
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_vid_rvalid", bus.vid_rvalid, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_gnt", bus.cpu_gnt, 0);
    chk("rst_timeout", bus.cpu_timeout, 0);
    chk("rst_rdata", {bus.vid_rdata, bus.cpu_rdata}, 0);

    // reset with two reads in flight
    rst = 1;
    bus.vid_req = 1; bus.vid_addr = 32'h10;
    tick();
    bus.vid_req = 0; bus.cpu_req = 1; bus.cpu_addr = 32'h20;
    #1 chk("inflight_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 0;
    chk("inflight_mem_addr", bus.mem_addr, 32'h20);
    rst = 0;
    #1;
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_rvalid", {bus.vid_rvalid, bus.cpu_rvalid}, 0);
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rvalid", {bus.vid_rvalid, bus.cpu_rvalid}, 0);
    end

    // video burst 0x39c..0x3a8
    for (int i = 0; i < 6; i++) begin
      bus.vid_req  = (i < 4);
      bus.vid_addr = 32'h39C + 32'(4 * i);
      tick();
      if (i < 4) chk("vid_mem_addr", bus.mem_addr, 32'h39C + 32'(4 * i));
      if (i >= 2) begin
        chk("vid_rvalid", bus.vid_rvalid, 1);
        chk("vid_rdata", bus.vid_rdata, vexp[i-2]);
        chk("vid_no_cpu_rvalid", bus.cpu_rvalid, 0);
      end
    end
    bus.vid_req = 0;
    tick();
    chk("vid_rvalid_end", bus.vid_rvalid, 0);

    // cpu single read of 0x100
    bus.cpu_req = 1; bus.cpu_addr = 32'h100;
    #1 chk("cpu_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 0;
    #1 chk("cpu_gnt_drop", bus.cpu_gnt, 0);
    chk("cpu_mem_addr", bus.mem_addr, 32'h100);
    tick();
    chk("cpu_rvalid_k1", bus.cpu_rvalid, 0);
    tick();
    chk("cpu_rvalid_k2", bus.cpu_rvalid, 1);
    chk("cpu_rdata", bus.cpu_rdata, 32'hDEAD_0100);
    chk("cpu_no_vid_rvalid", bus.vid_rvalid, 0);
    tick();
    chk("cpu_rvalid_pulse", bus.cpu_rvalid, 0);
    chk("cpu_rdata_hold", bus.cpu_rdata, 32'hDEAD_0100);

    // contention: video holds the port for 10 cycles
    bus.vid_req = 1; bus.vid_addr = 32'h200; bus.cpu_req = 1; bus.cpu_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      #1 chk("cont_no_gnt", bus.cpu_gnt, 0);
      tick();
      chk("cont_wait_cnt", 64'(dut.cpu_wait_cnt), i + 1);
    end
    bus.vid_req = 0;
    #1 chk("cont_gnt", bus.cpu_gnt, 1);
    chk("cont_cnt_peak", 64'(dut.cpu_wait_cnt), 10);
    chk("cont_timeout_hi", bus.cpu_timeout, 1);
    tick();
    bus.cpu_req = 0;
    chk("cont_cnt_clr", 64'(dut.cpu_wait_cnt), 0);
    chk("cont_timeout_lo", bus.cpu_timeout, 0);
    chk("cont_mem_addr", bus.mem_addr, 32'h300);
    tick();
    chk("cont_last_vid", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b10);
    chk("cont_last_vid_data", bus.vid_rdata, 32'hDEAD_0200);
    tick();
    chk("cont_cpu_rvalid", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b01);
    chk("cont_cpu_rdata", bus.cpu_rdata, 32'hDEAD_0300);

    // timeout: rises after 4 wait cycles
    bus.vid_req = 1; bus.vid_addr = 32'h204; bus.cpu_req = 1; bus.cpu_addr = 32'h304;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_timeout", bus.cpu_timeout, (i + 1 >= 4));
    end
    bus.vid_req = 0;
    #1 chk("to_gnt", bus.cpu_gnt, 1);
    chk("to_hi_at_gnt", bus.cpu_timeout, 1);
    tick();
    bus.cpu_req = 0;
    chk("to_fall", bus.cpu_timeout, 0);
    tick(); tick(); tick();

    // abort: cpu_req drops without a grant
    bus.vid_req = 1; bus.cpu_req = 1; bus.cpu_addr = 32'h3F0;
    tick(); tick();
    chk("abort_cnt", 64'(dut.cpu_wait_cnt), 2);
    bus.vid_req = 0; bus.cpu_req = 0;
    tick();
    chk("abort_cnt_clr", 64'(dut.cpu_wait_cnt), 0);
    tick(); tick(); tick();
    chk("abort_no_cpu_rvalid", bus.cpu_rvalid, 0);

    // interleave V,C,V,C
    bus.vid_req = 1; bus.vid_addr = 32'h400; bus.cpu_req = 1; bus.cpu_addr = 32'h500;
    tick();
    bus.vid_req = 0;
    #1 chk("il_gnt0", bus.cpu_gnt, 1);
    tick();
    bus.vid_req = 1; bus.vid_addr = 32'h408; bus.cpu_addr = 32'h504;
    tick();
    chk("il_v0", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b10);
    chk("il_v0_data", bus.vid_rdata, 32'hDEAD_0400);
    bus.vid_req = 0;
    #1 chk("il_gnt1", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 0;
    chk("il_c0", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b01);
    chk("il_c0_data", bus.cpu_rdata, 32'hDEAD_0500);
    chk("il_v_hold", bus.vid_rdata, 32'hDEAD_0400);
    tick();
    chk("il_v1", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b10);
    chk("il_v1_data", bus.vid_rdata, 32'hDEAD_0408);
    tick();
    chk("il_c1", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b01);
    chk("il_c1_data", bus.cpu_rdata, 32'hDEAD_0504);
    tick();
    chk("il_idle", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
